// File: rtl/piano_key_tracker.sv
// Piano key tracker: turns PS/2 make/break events into a frame-synchronous
// "most recently pressed key" index plus a per-key held mask and hold counter.
module piano_key_tracker #(
  parameter int NUM_KEYS = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [8:0]          key_code,
  input  logic                key_is_down,
  input  logic                frame_tick,
  output logic [2:0]          key_press,
  output logic                key_active,
  output logic [NUM_KEYS-1:0] held_mask,
  output logic [7:0]          hold_frames
);

  localparam logic [2:0] NONE = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_dec_t;

  logic [NUM_KEYS-1:0]       held, held_n;
  logic [NUM_KEYS-1:0][2:0]  stack, stack_n;
  logic [NUM_KEYS:0][2:0]    ext;
  logic [2:0]                depth, depth_n;
  logic [2:0]                cur, cur_n;
  key_dec_t                  dec;
  logic                      found;

  always_comb begin
    dec = '{hit: 1'b1, idx: 3'd0};
    case (key_code)
      9'h01C: dec.idx = 3'd0;
      9'h01B: dec.idx = 3'd1;
      9'h023: dec.idx = 3'd2;
      9'h02B: dec.idx = 3'd3;
      9'h034: dec.idx = 3'd4;
      9'h033: dec.idx = 3'd5;
      9'h03B: dec.idx = 3'd6;
      default: dec = '{hit: 1'b0, idx: 3'd0};
    endcase
  end

  // Padded copy so compaction can read one slot past the bottom.
  assign ext = {NONE, stack};

  always_comb begin
    held_n  = held;
    stack_n = stack;
    depth_n = depth;
    cur_n   = cur;
    found   = 1'b0;
    if (key_valid && dec.hit) begin
      if (key_is_down && !held[dec.idx]) begin
        held_n[dec.idx] = 1'b1;
        stack_n = {stack[NUM_KEYS-2:0], dec.idx};
        depth_n = depth + 3'd1;
        cur_n   = dec.idx;
      end else if (!key_is_down && held[dec.idx]) begin
        held_n[dec.idx] = 1'b0;
        // Slot 0 is the top; everything at or below the removed key shifts up.
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (3'(i) < depth && stack[i] == dec.idx) found = 1'b1;
          if (found) stack_n[i] = ext[i+1];
        end
        depth_n = depth - 3'd1;
        cur_n   = (depth_n == 3'd0) ? NONE : stack_n[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held        <= '0;
      stack       <= {NUM_KEYS{NONE}};
      depth       <= 3'd0;
      cur         <= NONE;
      key_press   <= NONE;
      hold_frames <= 8'd0;
    end else begin
      held  <= held_n;
      stack <= stack_n;
      depth <= depth_n;
      cur   <= cur_n;
      if (frame_tick) begin
        key_press <= cur_n;
        if (cur_n == NONE)
          hold_frames <= 8'd0;
        else if (cur_n == key_press)
          hold_frames <= (hold_frames == 8'd255) ? 8'd255 : hold_frames + 8'd1;
        else
          hold_frames <= 8'd1;
      end
    end
  end

  assign key_active = (key_press != NONE);
  assign held_mask  = held;

endmodule

// File: tb/tb_piano_key_tracker.sv
// Scoreboard bench for piano_key_tracker: expected frame outputs are queued as
// ticks are driven and popped when the latched values are sampled.
module tb_piano_key_tracker;
  logic       clk = 1'b0;
  logic       rst, key_valid, key_is_down, frame_tick;
  logic [8:0] key_code;
  logic [2:0] key_press;
  logic       key_active;
  logic [6:0] held_mask;
  logic [7:0] hold_frames;

  typedef struct packed {
    logic [2:0] kp;
    logic [7:0] hf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  piano_key_tracker #(.NUM_KEYS(7)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_is_down(key_is_down), .frame_tick(frame_tick), .key_press(key_press),
    .key_active(key_active), .held_mask(held_mask), .hold_frames(hold_frames)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cyc(input logic v, input logic [8:0] c, input logic d, input logic t);
    key_valid = v; key_code = c; key_is_down = d; frame_tick = t;
    @(negedge clk);
    key_valid = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (key_press !== 3'd7 || hold_frames !== 8'd0 || held_mask !== 7'd0 || key_active !== 1'b0) begin
      failures++;
      $display("FAIL reset: kp=%0d hf=%0d mask=%b act=%b required 7/0/0000000/0",
               key_press, hold_frames, held_mask, key_active);
    end
  endtask

  task automatic test_first_press;
    repeat (9) cyc(0, 9'h000, 0, 0);
    cyc(1, 9'h01C, 1, 0);
    checks++;
    if (held_mask !== 7'b0000001 || key_press !== 3'd7) begin
      failures++;
      $display("FAIL first_press_mask: mask=%b kp=%0d required 0000001/7", held_mask, key_press);
    end
    repeat (9) cyc(0, 9'h000, 0, 0);
    checks++;
    if (key_press !== 3'd7 || hold_frames !== 8'd0) begin
      failures++;
      $display("FAIL first_press_pre_tick: kp=%0d hf=%0d required 7/0", key_press, hold_frames);
    end
    exp_q.push_back('{3'd0, 8'd1});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf || key_active !== 1'b1) begin
      failures++;
      $display("FAIL first_press_tick: kp=%0d hf=%0d act=%b required %0d/%0d/1",
               key_press, hold_frames, key_active, e.kp, e.hf);
    end
  endtask

  task automatic test_sequence;
    logic [8:0] codes[3] = '{9'h023, 9'h034, 9'h034};
    logic       downs[3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0] kps[3]   = '{3'd2, 3'd4, 3'd2};
    for (int i = 0; i < 3; i++) begin
      cyc(1, codes[i], downs[i], 0);
      exp_q.push_back('{kps[i], 8'd1});
      cyc(0, 9'h000, 0, 1);
      e = exp_q.pop_front();
      checks++;
      if (key_press !== e.kp || hold_frames !== e.hf) begin
        failures++;
        $display("FAIL sequence[%0d]: kp=%0d hf=%0d required %0d/%0d", i, key_press, hold_frames, e.kp, e.hf);
      end
    end
    for (int i = 2; i <= 4; i++) begin
      exp_q.push_back('{3'd2, 8'(i)});
      cyc(0, 9'h000, 0, 1);
      e = exp_q.pop_front();
      checks++;
      if (key_press !== e.kp || hold_frames !== e.hf) begin
        failures++;
        $display("FAIL hold_count[%0d]: kp=%0d hf=%0d required %0d/%0d", i, key_press, hold_frames, e.kp, e.hf);
      end
    end
    cyc(1, 9'h023, 0, 0);
    cyc(1, 9'h01C, 0, 0);
    exp_q.push_back('{3'd7, 8'd0});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf || held_mask !== 7'd0) begin
      failures++;
      $display("FAIL sequence_clear: kp=%0d hf=%0d mask=%b required %0d/%0d/0", key_press, hold_frames, held_mask, e.kp, e.hf);
    end
  endtask

  task automatic test_typematic;
    int exp_hf = 1;
    int bad = 0;
    cyc(1, 9'h01B, 1, 0);
    exp_q.push_back('{3'd1, 8'd1});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf) begin
      failures++;
      $display("FAIL typematic_first: kp=%0d hf=%0d required %0d/%0d", key_press, hold_frames, e.kp, e.hf);
    end
    for (int i = 1; i <= 300; i++) begin
      cyc(1, 9'h01B, 1, 0);
      if (exp_hf < 255) exp_hf++;
      exp_q.push_back('{3'd1, 8'(exp_hf)});
      cyc(0, 9'h000, 0, 1);
      e = exp_q.pop_front();
      checks++;
      if ((key_press !== e.kp || hold_frames !== e.hf) && bad < 5) begin
        bad++;
        $display("FAIL typematic[%0d]: kp=%0d hf=%0d required %0d/%0d", i, key_press, hold_frames, e.kp, e.hf);
      end
      if (key_press !== e.kp || hold_frames !== e.hf) failures++;
    end
    cyc(1, 9'h01B, 0, 0);
    exp_q.push_back('{3'd7, 8'd0});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf || key_active !== 1'b0) begin
      failures++;
      $display("FAIL typematic_release: kp=%0d hf=%0d act=%b required %0d/%0d/0", key_press, hold_frames, key_active, e.kp, e.hf);
    end
  endtask

  task automatic test_same_cycle;
    exp_q.push_back('{3'd6, 8'd1});
    cyc(1, 9'h03B, 1, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf) begin
      failures++;
      $display("FAIL same_cycle: kp=%0d hf=%0d required %0d/%0d", key_press, hold_frames, e.kp, e.hf);
    end
    cyc(1, 9'h033, 1, 0);
    cyc(1, 9'h033, 0, 0);
    exp_q.push_back('{3'd6, 8'd2});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf) begin
      failures++;
      $display("FAIL hidden_tap: kp=%0d hf=%0d required %0d/%0d", key_press, hold_frames, e.kp, e.hf);
    end
    cyc(1, 9'h03B, 0, 0);
    exp_q.push_back('{3'd7, 8'd0});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf) begin
      failures++;
      $display("FAIL same_cycle_clear: kp=%0d hf=%0d required %0d/%0d", key_press, hold_frames, e.kp, e.hf);
    end
  endtask

  task automatic test_stack_order;
    cyc(1, 9'h01C, 1, 0);
    cyc(1, 9'h02B, 1, 0);
    cyc(1, 9'h033, 1, 0);
    checks++;
    if (held_mask !== 7'b0101001) begin
      failures++;
      $display("FAIL stack_mask: mask=%b required 0101001", held_mask);
    end
    cyc(1, 9'h02B, 0, 0);
    exp_q.push_back('{3'd5, 8'd1});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf) begin
      failures++;
      $display("FAIL stack_break_mid: kp=%0d hf=%0d required %0d/%0d", key_press, hold_frames, e.kp, e.hf);
    end
    cyc(1, 9'h033, 0, 0);
    exp_q.push_back('{3'd0, 8'd1});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf) begin
      failures++;
      $display("FAIL stack_break_top: kp=%0d hf=%0d required %0d/%0d", key_press, hold_frames, e.kp, e.hf);
    end
    cyc(1, 9'h01C, 0, 0);
    exp_q.push_back('{3'd7, 8'd0});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf || held_mask !== 7'd0) begin
      failures++;
      $display("FAIL stack_empty: kp=%0d hf=%0d mask=%b required %0d/%0d/0", key_press, hold_frames, held_mask, e.kp, e.hf);
    end
  endtask

  task automatic test_back_to_back;
    cyc(1, 9'h01C, 1, 0);
    cyc(1, 9'h01B, 1, 0);
    cyc(1, 9'h023, 1, 0);
    checks++;
    if (held_mask !== 7'b0000111) begin
      failures++;
      $display("FAIL b2b_mask: mask=%b required 0000111", held_mask);
    end
    exp_q.push_back('{3'd2, 8'd1});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf) begin
      failures++;
      $display("FAIL b2b_press: kp=%0d hf=%0d required %0d/%0d", key_press, hold_frames, e.kp, e.hf);
    end
    cyc(1, 9'h023, 0, 0);
    cyc(1, 9'h01C, 0, 0);
    exp_q.push_back('{3'd1, 8'd1});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf || held_mask !== 7'b0000010) begin
      failures++;
      $display("FAIL b2b_release: kp=%0d hf=%0d mask=%b required %0d/%0d/0000010", key_press, hold_frames, held_mask, e.kp, e.hf);
    end
    cyc(1, 9'h01B, 0, 0);
    cyc(0, 9'h000, 0, 1);
  endtask

  task automatic test_ignored_and_reset;
    cyc(1, 9'h02B, 0, 0);
    cyc(1, 9'h11C, 1, 0);
    cyc(1, 9'h015, 1, 0);
    checks++;
    if (held_mask !== 7'd0) begin
      failures++;
      $display("FAIL ignored_mask: mask=%b required 0000000", held_mask);
    end
    exp_q.push_back('{3'd7, 8'd0});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf) begin
      failures++;
      $display("FAIL ignored_tick: kp=%0d hf=%0d required %0d/%0d", key_press, hold_frames, e.kp, e.hf);
    end
    cyc(1, 9'h034, 1, 0);
    exp_q.push_back('{3'd4, 8'd1});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf || held_mask !== 7'b0010000) begin
      failures++;
      $display("FAIL held4: kp=%0d hf=%0d mask=%b required %0d/%0d/0010000", key_press, hold_frames, held_mask, e.kp, e.hf);
    end
    rst = 1'b1;
    cyc(1, 9'h01C, 1, 1);
    rst = 1'b0;
    checks++;
    if (key_press !== 3'd7 || hold_frames !== 8'd0 || held_mask !== 7'd0 || key_active !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: kp=%0d hf=%0d mask=%b act=%b required 7/0/0000000/0",
               key_press, hold_frames, held_mask, key_active);
    end
    cyc(1, 9'h034, 0, 0);
    exp_q.push_back('{3'd7, 8'd0});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf || held_mask !== 7'd0) begin
      failures++;
      $display("FAIL post_reset_break: kp=%0d hf=%0d mask=%b required %0d/%0d/0", key_press, hold_frames, held_mask, e.kp, e.hf);
    end
    // A fresh press after reset must work from an empty stack.
    cyc(1, 9'h033, 1, 0);
    exp_q.push_back('{3'd5, 8'd1});
    cyc(0, 9'h000, 0, 1);
    e = exp_q.pop_front();
    checks++;
    if (key_press !== e.kp || hold_frames !== e.hf) begin
      failures++;
      $display("FAIL post_reset_press: kp=%0d hf=%0d required %0d/%0d", key_press, hold_frames, e.kp, e.hf);
    end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = '0; key_is_down = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_first_press();
    test_sequence();
    test_typematic();
    test_same_cycle();
    test_stack_order();
    test_back_to_back();
    test_ignored_and_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
